// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, PC source select, fetch FSM states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] FUNCT_ADD = 6'h20;

  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'b00,
    PC_SRC_ALUOUT = 2'b01,
    PC_SRC_JUMP   = 2'b10,
    PC_SRC_HOLD   = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    FS_IDLE = 2'b00,
    FS_REQ  = 2'b01,
    FS_WAIT = 2'b10
  } fetch_state_e;

  typedef enum logic {
    KIND_INSTR = 1'b0,
    KIND_DATA  = 1'b1
  } access_kind_e;

  // Pseudo-direct jump target: upper PC nibble, 26-bit index, word aligned.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_cur,
                                              input logic [25:0] idx);
    return {pc_cur[31:28], idx, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Read-only memory port: req/ready request handshake, rvalid data return.
interface fetch_unit_if;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;

  modport master (output mem_addr, mem_req, input mem_ready, mem_rdata, mem_rvalid);
  modport slave  (input mem_addr, mem_req, output mem_ready, mem_rdata, mem_rvalid);
endinterface

// File: rtl/pc_reg.sv
// Program counter register with next-PC select and stall-gated enable.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        pc_write,
  input  logic        branch,
  input  logic        zero,
  input  logic [1:0]  pc_src,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_out,
  input  logic [25:0] instr_idx,
  output logic [31:0] pc
);

  logic [31:0] pc_q, pc_d;
  logic        pc_en;

  // Next PC: commands are ignored while an access is pending.
  always_comb begin
    pc_en = ~stall & (pc_write | (branch & zero));
    pc_d  = pc_q;
    if (pc_en) begin
      case (pc_src_e'(pc_src))
        PC_SRC_ALU:    pc_d = alu_result;
        PC_SRC_ALUOUT: pc_d = alu_out;
        PC_SRC_JUMP:   pc_d = jump_target(pc_q, instr_idx);
        default:       pc_d = pc_q;
      endcase
    end
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: PC/IR/MDR, memory access FSM, IR field slicing, stall generation.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ir_write,
  input  logic         mem_read,
  input  logic         iord,
  input  logic         pc_write,
  input  logic         branch,
  input  logic         zero,
  input  logic [1:0]   pc_src,
  input  logic [31:0]  alu_result,
  input  logic [31:0]  alu_out,
  fetch_unit_if.master mem,
  output logic [31:0]  pc,
  output logic [31:0]  instr,
  output logic [5:0]   opcode,
  output logic [4:0]   rs,
  output logic [4:0]   rt,
  output logic [4:0]   rd,
  output logic [5:0]   funct,
  output logic [15:0]  imm,
  output logic [31:0]  mdr,
  output logic         stall,
  output logic         err
);

  fetch_state_e state_q, state_d;
  access_kind_e kind_q, kind_d;
  logic [31:0]  addr_q, addr_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [31:0]  ir_q, ir_d;
  logic [31:0]  mdr_q, mdr_d;
  logic         err_q, err_d;
  logic         iserved_q, iserved_d;
  logic         dserved_q, dserved_d;
  logic         want_instr, want_data, stall_c, finish;

  // The controller holds ir_write/mem_read until it sees stall low. Each
  // request is serviced once per controller state: the served flags mask a
  // completed request so stall can drop, and clear on the edge where it does.
  always_comb begin
    want_instr = ir_write & ~iserved_q;
    want_data  = mem_read & ~dserved_q;
    state_d    = state_q;
    kind_d     = kind_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    ir_d       = ir_q;
    mdr_d      = mdr_q;
    err_d      = err_q;
    iserved_d  = iserved_q;
    dserved_d  = dserved_q;
    finish     = 1'b0;
    stall_c    = (state_q != FS_IDLE);

    case (state_q)
      FS_IDLE: begin
        if (want_instr) begin
          state_d = FS_REQ;
          kind_d  = KIND_INSTR;
          addr_d  = pc;
          stall_c = 1'b1;
        end else if (want_data) begin
          state_d = FS_REQ;
          kind_d  = KIND_DATA;
          addr_d  = alu_out;
          stall_c = 1'b1;
        end
      end
      FS_REQ: begin
        if (mem.mem_ready) begin
          state_d = FS_WAIT;
          cnt_d   = '0;
        end
      end
      FS_WAIT: begin
        if (mem.mem_rvalid) begin
          if (kind_q == KIND_INSTR) ir_d  = mem.mem_rdata;
          else                      mdr_d = mem.mem_rdata;
          finish = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TIMEOUT) begin
            err_d  = 1'b1;
            finish = 1'b1;
          end
        end
      end
      default: state_d = FS_IDLE;
    endcase

    if (finish) begin
      state_d = FS_IDLE;
      if (kind_q == KIND_INSTR) iserved_d = 1'b1;
      else                      dserved_d = 1'b1;
    end

    if (!stall_c) begin
      iserved_d = 1'b0;
      dserved_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FS_IDLE;
      kind_q    <= KIND_INSTR;
      addr_q    <= '0;
      cnt_q     <= '0;
      ir_q      <= '0;
      mdr_q     <= '0;
      err_q     <= 1'b0;
      iserved_q <= 1'b0;
      dserved_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      ir_q      <= ir_d;
      mdr_q     <= mdr_d;
      err_q     <= err_d;
      iserved_q <= iserved_d;
      dserved_q <= dserved_d;
    end
  end

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall_c),
    .pc_write   (pc_write),
    .branch     (branch),
    .zero       (zero),
    .pc_src     (pc_src),
    .alu_result (alu_result),
    .alu_out    (alu_out),
    .instr_idx  (ir_q[25:0]),
    .pc         (pc)
  );

  assign mem.mem_req  = (state_q == FS_REQ);
  assign mem.mem_addr = (state_q == FS_IDLE) ? (iord ? alu_out : pc) : addr_q;

  assign instr  = ir_q;
  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign funct  = ir_q[5:0];
  assign imm    = ir_q[15:0];
  assign mdr    = mdr_q;
  assign stall  = stall_c;
  assign err    = err_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Upstream neighbour of the multicycle main controller.
- Holds PC, the Instruction Register (IR) and the Memory Data Register (MDR). Issues instruction and data reads to a variable-latency memory using a req/ready plus rvalid handshake.
- Slices IR into opcode/funct/register/immediate fields for the controller and datapath.
- Raises `stall` so the controller holds its state while a memory access is outstanding.
- Applies controller PC-update commands: sequential, branch and jump.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 8'd255, cycles allowed from accepted request to rvalid before err is set.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ir_write  in  1  controller: fetch instruction at PC into IR.
- mem_read  in  1  controller: read data at alu_out into MDR.
- iord  in  1  address select: 0 = PC, 1 = alu_out.
- pc_write  in  1  unconditional PC update.
- branch  in  1  conditional PC update, qualified by zero.
- zero  in  1  ALU zero flag.
- pc_src  in  2  00 alu_result, 01 alu_out, 10 jump target, 11 hold.
- alu_result  in  32  combinational ALU output.
- alu_out  in  32  registered ALU output.
- mem_addr  out  32  memory address.
- mem_req  out  1  read request.
- mem_ready  in  1  memory accepts request.
- mem_rdata  in  32  read data.
- mem_rvalid  in  1  read data valid.
- pc  out  32  current PC.
- instr  out  32  IR contents.
- opcode  out  6  instr[31:26].
- rs  out  5  instr[25:21].
- rt  out  5  instr[20:16].
- rd  out  5  instr[15:11].
- funct  out  6  instr[5:0].
- imm  out  16  instr[15:0].
- mdr  out  32  MDR contents.
- stall  out  1  access pending; controller must hold state.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset values: pc = RESET_PC; IR = 0; MDR = 0; mem_req = 0; stall = 0; err = 0; FSM = IDLE; timeout counter = 0.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - ir_write = 1: go to REQ with kind = INSTR; address = pc.
  - Else mem_read = 1: go to REQ with kind = DATA; address = alu_out.
  - ir_write has priority when both are asserted. mem_read stays held by the controller (stalled) and is serviced afterwards.
- REQ:
  - mem_req = 1.
  - mem_addr is registered at entry and held stable until accepted.
  - On mem_ready: go to WAIT and clear the counter.
- WAIT:
  - Counter increments each cycle.
  - On mem_rvalid: INSTR latches IR, DATA latches MDR; go to IDLE.
  - Data is visible on instr/mdr the cycle after rvalid.
  - mem_ready and mem_rvalid in the same cycle as REQ exit are not combined: rvalid is only sampled in WAIT.
- mem_rvalid in IDLE or REQ is ignored.
- Timeout: counter reaches TIMEOUT in WAIT → err = 1 (sticky until rst), FSM returns to IDLE, IR/MDR unchanged.
- stall:
  - Combinational: 1 when FSM ≠ IDLE, or when (ir_write|mem_read) is seen in IDLE.
  - Low in the cycle after rvalid.
  - Minimum access latency is 3 cycles (IDLE→REQ→WAIT→IDLE).
- mem_addr in IDLE follows iord: pc if iord = 0, else alu_out.
- PC update, every edge where stall = 0:
  - pc_en = pc_write | (branch & zero).
  - Next PC is chosen by pc_src: alu_result, alu_out, or {pc[31:28], instr[25:0], 2'b00}; 11 holds.
- While stall = 1, pc_write/branch are ignored. The controller holds them, so the update occurs when stall drops, i.e. after the IR capture. The jump target then uses the new IR.
- PC arithmetic wraps modulo 2^32; no alignment check.
- Reset mid-access: FSM goes to IDLE, mem_req drops the same edge; a late rvalid is ignored.

Decomposition:
- Shared package mips_pkg:
  - opcode constants OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_ORI = 6'h0d; FUNCT_ADD = 6'h20.
  - pc_src encodings.
  - Fetch FSM state typedef.
- One sub-module, pc_reg: PC register, next-PC mux and enable logic.
- Field slicing and the access FSM stay at top level.

Test Plan:
- Reset then ir_write = 1, memory ready immediately, rvalid 1 cycle later with 32'h2008_0005:
  - mem_addr = 32'h0, stall high 3 cycles.
  - opcode = 6'h08, rt = 8, imm = 16'h0005.
  - pc = 32'h4 after stall drops with pc_write = 1, pc_src = 00, alu_result = 32'h4.
- Fetch with mem_ready delayed 4 cycles and rvalid delayed 6 cycles: mem_addr and mem_req stable throughout; IR updates exactly once.
- ir_write and mem_read both asserted with iord = 1, alu_out = 32'h40: instruction fetch first (addr 32'h0), then data read at 32'h40 latches mem_rdata = 32'hDEAD_BEEF into mdr; IR untouched.
- branch = 1, pc_src = 01, alu_out = 32'h100: zero = 0 → pc unchanged; zero = 1 → pc = 32'h100.
- IR = 32'h0800_0010, pc = 32'h4000_0004, pc_write = 1, pc_src = 10: pc = 32'h4000_0040.
- Fetch with no rvalid and TIMEOUT = 8: err = 1 and FSM back in IDLE after 8 WAIT cycles.
- Assert rst during WAIT: mem_req = 0 and pc = RESET_PC next cycle; a subsequent rvalid leaves IR = 0.
